// File: rtl/linear_mac_seq.sv
// Sequential fixed-point matrix-vector MAC: loads x, then streams y[r] = sum_c W[r][c]*x[c].
// Optional build macro LINEAR_MAC_RELU_EN clamps negative results to zero.
module linear_mac_seq #(
  parameter int unsigned N_ROWS    = 20,
  parameter int unsigned N_COLS    = 20,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [4:0]  w_row_addr,
  output logic [4:0]  w_col_addr,
  input  logic [31:0] w_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_row,
  output logic        done
);

  localparam int unsigned ColW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [4:0]  LastCol = 5'(N_COLS - 1);
  localparam logic [4:0]  LastRow = 5'(N_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCompute, StOutput} state_e;

  state_e             state_q, state_d;
  logic [4:0]         row_q, row_d;
  logic [4:0]         col_q, col_d;
  logic [4:0]         ld_idx_q, ld_idx_d;
  logic signed [68:0] acc_q, acc_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               done_q, done_d;
  logic               in_ready_q, in_ready_d;

  logic [31:0]        x_mem [N_COLS];
  logic               x_we;
  logic [31:0]        x_cur;
  logic signed [63:0] prod;
  logic signed [68:0] acc_sum;
  logic signed [68:0] acc_shr;
  logic [31:0]        sat;
  logic [31:0]        result;
  logic               in_xfer;

  assign in_xfer = in_valid && in_ready_q;
  assign x_cur   = x_mem[col_q[ColW-1:0]];
  assign prod    = $signed(w_data) * $signed(x_cur);
  assign acc_sum = acc_q + 69'(prod);
  assign acc_shr = acc_sum >>> FRAC_BITS;

  always_comb begin
    sat = acc_shr[31:0];
    if (!acc_shr[68] && (|acc_shr[67:31])) begin
      sat = 32'h7FFF_FFFF;
    end else if (acc_shr[68] && !(&acc_shr[67:31])) begin
      sat = 32'h8000_0000;
    end
  end

`ifdef LINEAR_MAC_RELU_EN
  assign result = sat[31] ? 32'h0000_0000 : sat;
`else
  assign result = sat;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    ld_idx_d   = ld_idx_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    x_we       = 1'b0;

    unique case (state_q)
      StIdle, StLoad: begin
        if (in_xfer) begin
          x_we = 1'b1;
          if (ld_idx_q == LastCol) begin
            state_d  = StCompute;
            ld_idx_d = '0;
            row_d    = '0;
            col_d    = '0;
            acc_d    = '0;
          end else begin
            state_d  = StLoad;
            ld_idx_d = ld_idx_q + 5'd1;
          end
        end
      end
      StCompute: begin
        acc_d = acc_sum;
        if (col_q == LastCol) begin
          // Final product is folded in here, so the result uses acc_sum, not acc_q.
          state_d    = StOutput;
          out_data_d = result;
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      StOutput: begin
        if (out_ready) begin
          if (row_q == LastRow) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StCompute;
            row_d   = row_q + 5'd1;
            col_d   = '0;
            acc_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle) || (state_d == StLoad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      ld_idx_q   <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ld_idx_q   <= ld_idx_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  // x storage is overwritten by every load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (x_we) begin
      x_mem[ld_idx_q[ColW-1:0]] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == StOutput);
  assign out_data   = out_data_q;
  assign out_row    = row_q;
  assign w_row_addr = row_q;
  assign w_col_addr = col_q;
  assign done       = done_q;

endmodule
